// File: rtl/instr_encoder_if.sv
// Request/instruction-memory bus between a program source and instr_encoder.
// The master drives encode requests; the slave answers with ready and the imem write port.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [4:0]        req_shamt;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;
    logic              req_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, req_last,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_imm, req_target, req_last,
        output req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into 32-bit MIPS words and writes them sequentially
// into instruction memory, tracking word count, completion and illegal opcodes.
module instr_encoder #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {IDLE, WRITE, FULL, DONE} state_t;
    typedef enum logic [1:0] {K_R, K_I, K_J} kind_t;

    state_t            state;
    logic              ready_q;
    logic              last_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  count_q;
    logic              done_q;
    logic              err_q;

    logic              hs_c;
    logic [ADDR_W-1:0] slot_c;
    logic              illegal_c;
    kind_t             kind_c;
    logic [4:0]        rs_c, rt_c, rd_c, sh_c;
    logic [5:0]        funct_c, opc_c;
    logic [31:0]       enc_c;

    assign bus.req_ready  = ready_q & ~clear;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign count          = count_q;
    assign done           = done_q;
    assign err            = err_q;

    assign hs_c   = bus.req_valid & bus.req_ready;
    // A write in flight has already claimed addr_q, so the next word lands one above it.
    assign slot_c = we_q ? addr_q + ADDR_W'(1) : addr_q;

    // Opcode decode, field zeroing and word assembly.
    always_comb begin
        kind_c    = K_R;
        illegal_c = 1'b0;
        rs_c      = bus.req_rs;
        rt_c      = bus.req_rt;
        rd_c      = bus.req_rd;
        sh_c      = 5'd0;
        funct_c   = 6'h00;
        opc_c     = 6'h00;
        case (bus.req_op)
            6'd0:  funct_c = 6'h20;
            6'd1:  funct_c = 6'h21;
            6'd2:  funct_c = 6'h22;
            6'd3:  funct_c = 6'h23;
            6'd4:  funct_c = 6'h24;
            6'd5:  funct_c = 6'h25;
            6'd6:  funct_c = 6'h26;
            6'd7:  funct_c = 6'h27;
            6'd8:  funct_c = 6'h2A;
            6'd9:  funct_c = 6'h2B;
            6'd10: begin funct_c = 6'h00; sh_c = bus.req_shamt; rs_c = 5'd0; end
            6'd11: funct_c = 6'h04;
            6'd12: begin funct_c = 6'h03; sh_c = bus.req_shamt; rs_c = 5'd0; end
            6'd13: funct_c = 6'h07;
            6'd14: begin funct_c = 6'h02; sh_c = bus.req_shamt; rs_c = 5'd0; end
            6'd15: funct_c = 6'h06;
            6'd16: begin funct_c = 6'h09; rt_c = 5'd0; end
            6'd17: begin funct_c = 6'h08; rt_c = 5'd0; rd_c = 5'd0; end
            6'd18: begin kind_c = K_I; opc_c = 6'h08; end
            6'd19: begin kind_c = K_I; opc_c = 6'h09; end
            6'd20: begin kind_c = K_I; opc_c = 6'h0C; end
            6'd21: begin kind_c = K_I; opc_c = 6'h0D; end
            6'd22: begin kind_c = K_I; opc_c = 6'h0E; end
            6'd23: begin kind_c = K_I; opc_c = 6'h0F; rs_c = 5'd0; end
            6'd24: begin kind_c = K_I; opc_c = 6'h0A; end
            6'd25: begin kind_c = K_I; opc_c = 6'h0B; end
            6'd26: begin kind_c = K_I; opc_c = 6'h23; end
            6'd27: begin kind_c = K_I; opc_c = 6'h2B; end
            6'd28: begin kind_c = K_I; opc_c = 6'h04; end
            6'd29: begin kind_c = K_I; opc_c = 6'h05; end
            6'd30: begin kind_c = K_J; opc_c = 6'h02; end
            6'd31: begin kind_c = K_J; opc_c = 6'h03; end
            default: illegal_c = 1'b1;
        endcase
        case (kind_c)
            K_I:     enc_c = {opc_c, rs_c, rt_c, bus.req_imm};
            K_J:     enc_c = {opc_c, bus.req_target};
            default: enc_c = {6'h00, rs_c, rt_c, rd_c, sh_c, funct_c};
        endcase
    end

    // Control FSM with registered imem port, status and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (clear) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                count_q <= count_q + CNT_W'(1);
                if (addr_q != ADDR_MAX) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (hs_c) begin
                if (illegal_c) begin
                    err_q <= 1'b1;
                    if (bus.req_last) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end else begin
                    we_q    <= 1'b1;
                    addr_q  <= slot_c;
                    wdata_q <= enc_c;
                    last_q  <= bus.req_last;
                    // The final program word stops intake during its own write cycle.
                    if (bus.req_last) begin
                        state   <= WRITE;
                        ready_q <= 1'b0;
                    end else if (slot_c == ADDR_MAX) begin
                        state   <= FULL;
                        ready_q <= 1'b0;
                    end else begin
                        state   <= WRITE;
                        ready_q <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    IDLE: ready_q <= 1'b1;
                    WRITE: begin
                        if (last_q) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                    default: ready_q <= 1'b0;
                endcase
            end
        end
    end
endmodule
